axi_acp_bram_writer: RTL



---
 rtl/axi_acp_bram_writer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_acp_bram_writer.sv
// BRAM-to-AXI3 (ACP) burst writer: streams sequential 128-bit BRAM words to a destination address.
// Optional feature macro ACP_WR_IRQ_EN: one-cycle irq pulse on entering DONE (irq tied 0 otherwise).

module axi_acp_bram_writer #(
  parameter int unsigned BRAM_AW = 10,
  parameter logic [7:0]  AXI_ID  = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        dst_addr,
  input  logic [31:0]        len_bytes,
  output logic [BRAM_AW-1:0] bram_addr,
  input  logic [127:0]       bram_rdata,
  output logic [7:0]         awid,
  output logic [31:0]        awaddr,
  output logic [3:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic [1:0]         awlock,
  output logic [3:0]         awcache,
  output logic [2:0]         awprot,
  output logic [4:0]         awuser,
  output logic               awvalid,
  input  logic               awready,
  output logic [7:0]         wid,
  output logic [127:0]       wdata,
  output logic [15:0]        wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [7:0]         bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic [31:0]        status,
  output logic               irq
);

  localparam int unsigned BW        = BRAM_AW + 1;
  localparam int unsigned DW        = 128;
  localparam logic [27:0] MAX_BEATS = 28'(64'd1 << BRAM_AW);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_start_q;
  logic [31:0]        r_addr;
  logic [BW-1:0]      r_beats_left, r_fetch_left;
  logic [4:0]         r_burst_len, r_beat;
  logic               r_wrap, r_err, r_done, r_pend;
  logic [1:0]         r_cnt;
  logic [DW-1:0]      r_fifo0, r_fifo1;
  logic [BRAM_AW-1:0] r_bram_addr;

  logic        w_accept, w_bad, w_zero, w_busy, w_issue, w_enter_done;
  logic        w_aw_hs, w_w_hs, w_b_hs;
  logic [8:0]  w_to_4k;
  logic [4:0]  w_lim, w_len;
  logic [2:0]  w_occ;
  logic [32:0] w_next_addr;
  logic        w_unused;

  assign w_accept     = start & ~r_start_q & (r_state == S_IDLE);
  assign w_bad        = (dst_addr[3:0] != 4'd0) || (len_bytes[31:4] > MAX_BEATS);
  assign w_zero       = (len_bytes[31:4] == 28'd0);
  assign w_aw_hs      = awvalid & awready;
  assign w_w_hs       = wvalid & wready;
  assign w_b_hs       = bvalid & bready;
  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

  // Burst length: min(16, remaining beats, beats left before the next 4 KB boundary)
  assign w_to_4k     = 9'd256 - {1'b0, r_addr[11:4]};
  assign w_lim       = (w_to_4k < 9'd16) ? w_to_4k[4:0] : 5'd16;
  assign w_len       = (32'(r_beats_left) < 32'(w_lim)) ? 5'(r_beats_left) : w_lim;
  assign w_next_addr = {1'b0, r_addr} + {24'd0, w_len, 4'd0};

  // Prefetch keeps buffered words plus the in-flight read at no more than two
  assign w_occ   = 3'(r_cnt) + 3'(r_pend) - 3'(w_w_hs);
  assign w_issue = w_busy && (r_fetch_left != '0) && (w_occ <= 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_bad || w_zero) ? S_DONE : S_ADDR;
      S_ADDR: if (w_aw_hs) w_next = S_DATA;
      S_DATA: if (w_w_hs && wlast) w_next = S_RESP;
      S_RESP: if (w_b_hs) w_next = ((r_beats_left != '0) && !r_wrap) ? S_ADDR : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      S_ADDR: begin
        awvalid = 1'b1;
        w_busy  = 1'b1;
      end
      S_DATA: begin
        w_busy = 1'b1;
        wvalid = (r_cnt != 2'd0);
        wlast  = (r_cnt != 2'd0) && (r_beat == r_burst_len - 5'd1);
      end
      S_RESP: begin
        bready = 1'b1;
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Transfer bookkeeping: address, beat counts, sticky status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q    <= 1'b0;
      r_addr       <= '0;
      r_beats_left <= '0;
      r_burst_len  <= '0;
      r_beat       <= '0;
      r_wrap       <= 1'b0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_start_q <= start;
      if (w_accept) begin
        r_addr       <= dst_addr;
        r_beats_left <= BW'(len_bytes[31:4]);
        r_err        <= w_bad;
        r_done       <= 1'b0;
        r_wrap       <= 1'b0;
      end else if (w_aw_hs) begin
        r_addr       <= w_next_addr[31:0];
        r_wrap       <= w_next_addr[32];
        r_beats_left <= r_beats_left - BW'(w_len);
        r_burst_len  <= w_len;
        r_beat       <= '0;
      end else if (w_w_hs) begin
        r_beat <= r_beat + 5'd1;
      end
      if (w_b_hs && ((bresp != 2'b00) || (r_wrap && (r_beats_left != '0)))) r_err <= 1'b1;
      if (w_enter_done) r_done <= 1'b1;
    end
  end

  // BRAM read issue and two-entry word buffer; head entry drives wdata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bram_addr  <= '0;
      r_fetch_left <= '0;
      r_pend       <= 1'b0;
      r_cnt        <= '0;
      r_fifo0      <= '0;
      r_fifo1      <= '0;
    end else if (w_accept) begin
      r_bram_addr  <= '0;
      r_fetch_left <= BW'(len_bytes[31:4]);
      r_pend       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_bram_addr  <= r_bram_addr + BRAM_AW'(1);
        r_fetch_left <= r_fetch_left - BW'(1);
      end
      case ({r_pend, w_w_hs})
        2'b10: begin
          if (r_cnt == 2'd0) r_fifo0 <= bram_rdata;
          else               r_fifo1 <= bram_rdata;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_fifo0 <= r_fifo1;
          r_cnt   <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_fifo0 <= bram_rdata;
          end else begin
            r_fifo0 <= r_fifo1;
            r_fifo1 <= bram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACP_WR_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= w_enter_done;
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign bram_addr = r_bram_addr;
  assign awid      = AXI_ID;
  assign awaddr    = r_addr;
  assign awlen     = 4'(w_len - 5'd1);
  assign awsize    = 3'b100;
  assign awburst   = 2'b01;
  assign awlock    = 2'b00;
  assign awcache   = 4'b1111;
  assign awprot    = 3'b000;
  assign awuser    = 5'b00001;
  assign wid       = AXI_ID;
  assign wdata     = r_fifo0;
  assign wstrb     = 16'hFFFF;
  assign status    = {29'd0, r_err, r_done, w_busy};
  assign w_unused  = ^{bid, len_bytes[3:0]};

endmodule
